opl3_write_sched: RTL and testbench

Write scheduler sitting between the bus-side OPL3 port decoders and the opl3 sound block. It accepts complete register writes {bank, index, data} from two requesters: A (native 0x388 ports) and B (Sound Blaster 0x220/0x228 mirror). It arbitrates round-robin into a small FIFO. It then replays each entry to opl3 as an index-phase / data-phase pair with edge-clean we pulses and a programmable holdoff. This frees the CPU-side decoders from OPL write-timing rules.

---
 rtl/opl3_sched_pkg.sv | 21 ++
 rtl/opl3_wr_fifo.sv | 56 +++++
 rtl/opl3_write_sched.sv | 162 ++++++++++++++++
 tb/tb_opl3_write_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_sched_pkg.sv
// Shared types for the OPL3 write scheduler: the queued write record and the
// replay state machine encoding.
package opl3_sched_pkg;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic       bank;
    logic [7:0] index;
    logic [7:0] data;
  } opl_wr_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/opl3_wr_fifo.sv
// Small synchronous FIFO of OPL register writes. The head entry is visible
// combinationally so the scheduler can pop and use it in the same cycle.
module opl3_wr_fifo import opl3_sched_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  opl_wr_t       push_data,
  input  logic          pop,
  output opl_wr_t       pop_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  opl_wr_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            do_push, do_pop;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);

endmodule

// File: rtl/opl3_write_sched.sv
// Round-robin merge of two register-write requesters into a FIFO, replayed to
// the opl3 core as index/data phase pairs with fixed pulse, gap and holdoff.
module opl3_write_sched import opl3_sched_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int PULSE = 2,
  parameter int GAP   = 4,
  parameter int HOLD  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic                     a_bank,
  input  logic [7:0]               a_index,
  input  logic [7:0]               a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic                     b_bank,
  input  logic [7:0]               b_index,
  input  logic [7:0]               b_data,
  output logic                     b_ready,
  output logic [1:0]               opl_addr,
  output logic [7:0]               opl_din,
  output logic                     opl_we,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD == 0) ? 0 : HOLD - 1);

  logic          last_a_q, last_a_d;
  logic          grant_a, grant_b, push, pop;
  opl_wr_t       push_data, head;
  logic          fifo_empty;

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              work_bank_q, work_bank_d;
  logic [7:0]        work_data_q, work_data_d;
  logic [1:0]        addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              we_q, we_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_a   = a_valid & (~b_valid | ~last_a_q);
    grant_b   = b_valid & ~grant_a;
    a_ready   = grant_a & ~full;
    b_ready   = grant_b & ~full;
    push      = a_ready | b_ready;
    push_data = a_ready ? opl_wr_t'({a_bank, a_index, a_data})
                        : opl_wr_t'({b_bank, b_index, b_data});
    last_a_d  = a_ready ? 1'b1 : (b_ready ? 1'b0 : last_a_q);
  end

  opl3_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .level     (level),
    .full      (full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_bank_d = work_bank_q;
    work_data_d = work_data_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = we_q;
    pop         = 1'b0;
    case (state_q)
      opl3_sched_pkg::IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          work_bank_d = head.bank;
          work_data_d = head.data;
          addr_d      = {head.bank, 1'b0};
          din_d       = head.index;
          we_d        = 1'b1;
          cnt_d       = PULSE_LD;
          state_d     = opl3_sched_pkg::ADDR;
        end
      end
      opl3_sched_pkg::ADDR: begin
        if (cnt_q == '0) begin
          we_d    = 1'b0;
          cnt_d   = GAP_LD;
          state_d = opl3_sched_pkg::GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      opl3_sched_pkg::GAP: begin
        if (cnt_q == '0) begin
          addr_d  = {work_bank_q, 1'b1};
          din_d   = work_data_q;
          we_d    = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = opl3_sched_pkg::DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      opl3_sched_pkg::DATA: begin
        if (cnt_q == '0) begin
          we_d    = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = (HOLD == 0) ? opl3_sched_pkg::IDLE : opl3_sched_pkg::HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      opl3_sched_pkg::HOLD: begin
        if (cnt_q == '0) begin
          state_d = opl3_sched_pkg::IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        we_d    = 1'b0;
        state_d = opl3_sched_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= opl3_sched_pkg::IDLE;
      cnt_q       <= '0;
      work_bank_q <= 1'b0;
      work_data_q <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      last_a_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_bank_q <= work_bank_d;
      work_data_q <= work_data_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      last_a_q    <= last_a_d;
    end
  end

  assign opl_addr = addr_q;
  assign opl_din  = din_q;
  assign opl_we   = we_q;
  assign busy     = ~fifo_empty | (state_q != opl3_sched_pkg::IDLE);

endmodule

// File: tb/tb_opl3_write_sched.sv
// Bench for opl3_write_sched: two instances (default timing, and a short
// zero-holdoff variant) checked every cycle against a schedule-based model.
module tb_opl3_write_sched;

  localparam int P0 = 2, G0 = 4, H0 = 32, D0 = 8;
  localparam int P1 = 1, G1 = 2, H1 = 0,  D1 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid [2];
  logic       a_bank  [2];
  logic [7:0] a_index [2];
  logic [7:0] a_data  [2];
  logic       b_valid [2];
  logic       b_bank  [2];
  logic [7:0] b_index [2];
  logic [7:0] b_data  [2];
  logic       a_ready [2];
  logic       b_ready [2];
  logic [1:0] opl_addr [2];
  logic [7:0] opl_din  [2];
  logic       opl_we   [2];
  logic       busy     [2];
  logic       full     [2];
  logic [3:0] level0;
  logic [2:0] level1;

  always #5 clk = ~clk;

  opl3_write_sched #(.DEPTH(D0), .PULSE(P0), .GAP(G0), .HOLD(H0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid[0]), .a_bank(a_bank[0]), .a_index(a_index[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_bank(b_bank[0]), .b_index(b_index[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .opl_addr(opl_addr[0]), .opl_din(opl_din[0]), .opl_we(opl_we[0]),
    .busy(busy[0]), .full(full[0]), .level(level0)
  );

  opl3_write_sched #(.DEPTH(D1), .PULSE(P1), .GAP(G1), .HOLD(H1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid[1]), .a_bank(a_bank[1]), .a_index(a_index[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_bank(b_bank[1]), .b_index(b_index[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .opl_addr(opl_addr[1]), .opl_din(opl_din[1]), .opl_we(opl_we[1]),
    .busy(busy[1]), .full(full[1]), .level(level1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: queue of accepted writes plus the pop cycle of the entry in flight;
  // outputs follow from the offset of the current cycle relative to that pop.
  logic [16:0] mq [2][16];
  int          m_head [2];
  int          m_cnt  [2];
  bit          m_act  [2];
  int          m_p    [2];
  logic [16:0] m_cur  [2];
  bit          m_last_a [2];
  int          e_addr [2];
  int          e_din  [2];
  bit          dut_acc_a [2];
  bit          dut_acc_b [2];

  function automatic int pp(input int k); return (k == 0) ? P0 : P1; endfunction
  function automatic int gg(input int k); return (k == 0) ? G0 : G1; endfunction
  function automatic int hh(input int k); return (k == 0) ? H0 : H1; endfunction
  function automatic int dd(input int k); return (k == 0) ? D0 : D1; endfunction
  function automatic int per(input int k); return 2 * pp(k) + gg(k) + hh(k); endfunction
  function automatic int lvl(input int k); return (k == 0) ? int'(level0) : int'(level1); endfunction

  function automatic bit m_idle(input int k);
    return (m_cnt[k] == 0) && (!m_act[k] || (cyc - m_p[k]) > per(k));
  endfunction

  task automatic chk(input string nm, input int k, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0; m_cnt[k] = 0; m_act[k] = 0; m_p[k] = 0;
      m_last_a[k] = 0; e_addr[k] = 0; e_din[k] = 0;
      dut_acc_a[k] = 0; dut_acc_b[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int o;
    bit we, bsy, fl, ga, gb, ra, rb;
    logic [16:0] cur;
    o   = cyc - m_p[k];
    cur = m_cur[k];
    we  = 0;
    if (m_act[k] && o >= 1) begin
      if (o <= pp(k) + gg(k)) begin
        e_addr[k] = int'({cur[16], 1'b0});
        e_din[k]  = int'(cur[15:8]);
      end else begin
        e_addr[k] = int'({cur[16], 1'b1});
        e_din[k]  = int'(cur[7:0]);
      end
      we = (o <= pp(k)) || (o > pp(k) + gg(k) && o <= 2 * pp(k) + gg(k));
    end
    bsy = (m_cnt[k] > 0) || (m_act[k] && o >= 1 && o <= per(k));
    fl  = (m_cnt[k] == dd(k));
    ga  = a_valid[k] && (!b_valid[k] || !m_last_a[k]);
    gb  = b_valid[k] && !ga;
    ra  = ga && !fl;
    rb  = gb && !fl;
    chk("opl_we",   k, int'(opl_we[k]),   int'(we));
    chk("opl_addr", k, int'(opl_addr[k]), e_addr[k]);
    chk("opl_din",  k, int'(opl_din[k]),  e_din[k]);
    chk("busy",     k, int'(busy[k]),     int'(bsy));
    chk("full",     k, int'(full[k]),     int'(fl));
    chk("level",    k, lvl(k),            m_cnt[k]);
    chk("a_ready",  k, int'(a_ready[k]),  int'(ra));
    chk("b_ready",  k, int'(b_ready[k]),  int'(rb));
    dut_acc_a[k] = a_valid[k] && a_ready[k];
    dut_acc_b[k] = b_valid[k] && b_ready[k];
    if (m_cnt[k] > 0 && (!m_act[k] || o > per(k))) begin
      m_cur[k]  = mq[k][m_head[k]];
      m_head[k] = (m_head[k] + 1) % 16;
      m_cnt[k]  = m_cnt[k] - 1;
      m_act[k]  = 1;
      m_p[k]    = cyc;
    end
    if (ra) begin
      mq[k][(m_head[k] + m_cnt[k]) % 16] = {a_bank[k], a_index[k], a_data[k]};
      m_cnt[k] = m_cnt[k] + 1;
      m_last_a[k] = 1;
    end else if (rb) begin
      mq[k][(m_head[k] + m_cnt[k]) % 16] = {b_bank[k], b_index[k], b_data[k]};
      m_cnt[k] = m_cnt[k] + 1;
      m_last_a[k] = 0;
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      a_valid[k] = 0; a_bank[k] = 0; a_index[k] = 0; a_data[k] = 0;
      b_valid[k] = 0; b_bank[k] = 0; b_index[k] = 0; b_data[k] = 0;
    end
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, returns at next posedge+1.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_idle(0) && m_idle(1)) begin
        ok = 1;
        break;
      end
      cycle();
    end
    chk("idle_wait", 0, int'(ok), 1);
  endtask

  task automatic scen1();
    clr();
    a_valid[0] = 1; a_bank[0] = 0; a_index[0] = 8'h20; a_data[0] = 8'h01;
    cycle();
    clr();
    for (int j = 1; j <= 42; j++) begin
      chk("s1_we",   0, int'(opl_we[0]),   int'(j == 2 || j == 3 || j == 8 || j == 9));
      chk("s1_addr", 0, int'(opl_addr[0]), (j < 8) ? 0 : 1);
      chk("s1_din",  0, int'(opl_din[0]),  (j < 2) ? 0 : ((j < 8) ? 32'h20 : 32'h01));
      chk("s1_busy", 0, int'(busy[0]),     int'(j >= 1 && j <= 41));
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d no finish", cyc);
    $fatal(1);
  end

  initial begin
    int n, maxl, nacc, na, nb;
    bit sawfull, found;
    int order [4];
    clr();
    model_reset();
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_we",   k, int'(opl_we[k]),   0);
      chk("rst_addr", k, int'(opl_addr[k]), 0);
      chk("rst_din",  k, int'(opl_din[k]),  0);
      chk("rst_busy", k, int'(busy[k]),     0);
      chk("rst_full", k, int'(full[k]),     0);
      chk("rst_level", k, lvl(k),           0);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Single A write, literal waveform.
    scen1();

    // Single B write to bank 1.
    b_valid[0] = 1; b_bank[0] = 1; b_index[0] = 8'h05; b_data[0] = 8'h01;
    cycle();
    clr();
    for (int j = 1; j <= 42; j++) begin
      if (j == 2) begin
        chk("s2_addr_idx", 0, int'(opl_addr[0]), 2);
        chk("s2_din_idx",  0, int'(opl_din[0]),  5);
      end
      if (j == 8) begin
        chk("s2_addr_dat", 0, int'(opl_addr[0]), 3);
        chk("s2_din_dat",  0, int'(opl_din[0]),  1);
      end
      if (j == 42) chk("s2_busy_end", 0, int'(busy[0]), 0);
      cycle();
    end

    // Both requesters valid: acceptance alternates starting with A.
    nacc = 0; na = 0; nb = 0;
    for (int i = 0; i < 20 && nacc < 4; i++) begin
      a_valid[0] = 1; a_bank[0] = 0; a_index[0] = 8'(8'h30 + na); a_data[0] = 8'(8'hA0 + na);
      b_valid[0] = 1; b_bank[0] = 1; b_index[0] = 8'(8'h40 + nb); b_data[0] = 8'(8'hB0 + nb);
      cycle();
      if (dut_acc_a[0]) begin order[nacc] = 0; nacc++; na++; end
      else if (dut_acc_b[0]) begin order[nacc] = 1; nacc++; nb++; end
    end
    clr();
    chk("s3_accepts", 0, nacc, 4);
    for (int i = 0; i < nacc; i++) chk("s3_order", 0, order[i], i % 2);
    wait_idle();

    // Twelve back-to-back A writes against an 8-deep FIFO.
    n = 0; maxl = 0; sawfull = 0;
    for (int i = 0; i < 1000 && n < 12; i++) begin
      a_valid[0] = 1; a_bank[0] = n[0]; a_index[0] = 8'(n + 1); a_data[0] = 8'(8'hC0 + n);
      cycle();
      if (dut_acc_a[0]) n++;
      if (lvl(0) > maxl) maxl = lvl(0);
      if (full[0]) sawfull = 1;
    end
    clr();
    chk("s4_accepted", 0, n, 12);
    chk("s4_peak_level", 0, maxl, 8);
    chk("s4_saw_full", 0, int'(sawfull), 1);
    wait_idle();

    // Reset during the data phase with entries still queued.
    for (int i = 0; i < 3; i++) begin
      a_valid[0] = 1; a_bank[0] = 1; a_index[0] = 8'(8'h60 + i); a_data[0] = 8'(8'h70 + i);
      cycle();
    end
    clr();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_act[0] && (cyc - m_p[0]) > P0 + G0 && (cyc - m_p[0]) <= 2 * P0 + G0) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk("s5_found_data", 0, int'(found), 1);
    chk("s5_we_before", 0, int'(opl_we[0]), 1);
    #2;
    rst_n = 0;
    #1;
    chk("s5_we_async", 0, int'(opl_we[0]), 0);
    chk("s5_level",    0, lvl(0),          0);
    chk("s5_busy",     0, int'(busy[0]),   0);
    chk("s5_full",     0, int'(full[0]),   0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
    scen1();
    wait_idle();

    // Zero holdoff instance: second index pulse follows one low IDLE cycle.
    clr();
    a_valid[1] = 1; a_bank[1] = 0; a_index[1] = 8'h11; a_data[1] = 8'h22;
    cycle();
    for (int j = 1; j <= 12; j++) begin
      chk("s6_we", 1, int'(opl_we[1]), int'(j == 2 || j == 5 || j == 7 || j == 10));
      if (j == 7) begin
        chk("s6_addr2", 1, int'(opl_addr[1]), 2);
        chk("s6_din2",  1, int'(opl_din[1]),  32'h33);
      end
      clr();
      if (j == 1) begin
        a_valid[1] = 1; a_bank[1] = 1; a_index[1] = 8'h33; a_data[1] = 8'h44;
      end
      cycle();
    end
    wait_idle();

    // Random traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        a_valid[k] = ($urandom_range(0, 7) < ((k == 0) ? 1 : 3));
        b_valid[k] = ($urandom_range(0, 7) < ((k == 0) ? 1 : 3));
        a_bank[k]  = 1'($urandom);
        b_bank[k]  = 1'($urandom);
        a_index[k] = 8'($urandom);
        b_index[k] = 8'($urandom);
        a_data[k]  = 8'($urandom);
        b_data[k]  = 8'($urandom);
      end
      cycle();
    end
    clr();
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
